// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through IF/ID/EXE/MEM/WB,
// drives the ALU control code and datapath strobes, and counts retired instructions.
module multi_cycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       AluCtrl,
  output logic             Halted,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EXE  = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_OR   = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b000100;
  localparam logic [5:0] OP_ORI  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_SEXT = 2'd1;
  localparam logic [1:0] SRCB_ZEXT = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;

  logic is_rtype;
  logic is_itype;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_j;
  logic is_halt;
  logic is_legal;

  // ALU operation for register and immediate arithmetic
  function automatic logic [1:0] alu_for(input logic [5:0] op);
    case (op)
      OP_SUB:        alu_for = ALU_SUB;
      OP_OR, OP_ORI: alu_for = ALU_OR;
      default:       alu_for = ALU_ADD;
    endcase
  endfunction

  function automatic logic [1:0] srcb_for(input logic [5:0] op);
    case (op)
      OP_ADDI: srcb_for = SRCB_SEXT;
      OP_ORI:  srcb_for = SRCB_ZEXT;
      default: srcb_for = SRCB_RT;
    endcase
  endfunction

  assign is_rtype = (Opcode == OP_ADD) || (Opcode == OP_SUB) || (Opcode == OP_OR);
  assign is_itype = (Opcode == OP_ADDI) || (Opcode == OP_ORI);
  assign is_lw    = (Opcode == OP_LW);
  assign is_sw    = (Opcode == OP_SW);
  assign is_beq   = (Opcode == OP_BEQ);
  assign is_j     = (Opcode == OP_J);
  assign is_halt  = (Opcode == OP_HALT);
  assign is_legal = is_rtype || is_itype || is_lw || is_sw || is_beq || is_j || is_halt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (MemReady) state_d = S_ID;
      end
      S_ID: begin
        if (is_halt)                 state_d = S_HALT;
        else if (is_j || !is_legal)  state_d = S_IF;
        else                         state_d = S_EXE;
      end
      S_EXE: begin
        if (is_beq)              state_d = S_IF;
        else if (is_lw || is_sw) state_d = S_MEM;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        if (MemReady) state_d = is_lw ? S_WB : S_IF;
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // An instruction retires when a post-fetch state hands control back to IF or HALT
  assign retire = ((state_q == S_ID) || (state_q == S_EXE) || (state_q == S_MEM) || (state_q == S_WB))
                  && ((state_d == S_IF) || (state_d == S_HALT));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = PC_PLUS4;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    AluSrcB  = SRCB_RT;
    AluCtrl  = ALU_ADD;
    Halted   = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_ID: begin
        if (is_j) begin
          PCWrite = 1'b1;
          PCSrc   = PC_JUMP;
        end
      end
      S_EXE: begin
        if (is_lw || is_sw) begin
          AluSrcB = SRCB_SEXT;
        end else if (is_beq) begin
          AluCtrl = ALU_SUB;
          PCSrc   = PC_BRANCH;
          PCWrite = Zero;
        end else begin
          AluCtrl = alu_for(Opcode);
          AluSrcB = srcb_for(Opcode);
        end
      end
      S_MEM: begin
        // address operands stay selected for the whole access
        AluSrcB  = SRCB_SEXT;
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = is_rtype;
        MemToReg = is_lw;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
    // Reset abandons any access in flight within the same cycle
    if (Reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign State      = state_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: per-cycle comparison against an instruction-level
// model plus directed instruction sequences with hand-computed expectations.
module tb_multi_cycle_ctrl;
  localparam int CNT_W = 8;

  localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BEQ = 5, C_J = 6, C_HALT = 7;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [5:0]       Opcode;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic [1:0]       PCSrc;
  logic             IRWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             RegWrite;
  logic             RegDst;
  logic             MemToReg;
  logic [1:0]       AluSrcB;
  logic [1:0]       AluCtrl;
  logic             Halted;
  logic [2:0]       State;
  logic [CNT_W-1:0] InstrCount;

  multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .AluSrcB(AluSrcB), .AluCtrl(AluCtrl), .Halted(Halted), .State(State),
    .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int cls(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010: cls = C_R;
      6'b000100, 6'b000101:            cls = C_I;
      6'b100111:                       cls = C_LW;
      6'b100110:                       cls = C_SW;
      6'b110000:                       cls = C_BEQ;
      6'b111000:                       cls = C_J;
      6'b111111:                       cls = C_HALT;
      default:                         cls = C_ILL;
    endcase
  endfunction

  function automatic logic [1:0] alu_of(input logic [5:0] op);
    case (op)
      6'b000001:            alu_of = 2'd1;
      6'b000010, 6'b000101: alu_of = 2'd2;
      default:              alu_of = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] srcb_of(input logic [5:0] op);
    case (op)
      6'b000100: srcb_of = 2'd1;
      6'b000101: srcb_of = 2'd2;
      default:   srcb_of = 2'd0;
    endcase
  endfunction

  // Instruction-level model: the phases still ahead of the current instruction
  int               ms;
  int               plan[$];
  logic [CNT_W-1:0] mcnt;
  bit               mvalid = 1'b0;

  task automatic advance();
    if (plan.size() == 0) begin
      ms   = 0;
      mcnt = mcnt + 1'b1;
    end else begin
      ms = plan.pop_front();
    end
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      ms = 0;
      mcnt = '0;
      plan.delete();
      mvalid = 1'b1;
    end else if (mvalid) begin
      case (ms)
        0: if (MemReady) ms = 1;
        1: begin
          case (cls(Opcode))
            C_HALT:       begin ms = 5; mcnt = mcnt + 1'b1; end
            C_J, C_ILL:   begin ms = 0; mcnt = mcnt + 1'b1; end
            C_R, C_I:     begin plan = '{4};    ms = 2; end
            C_LW:         begin plan = '{3, 4}; ms = 2; end
            C_SW:         begin plan = '{3};    ms = 2; end
            default:      begin plan.delete();  ms = 2; end
          endcase
        end
        2, 4: advance();
        3: if (MemReady) advance();
        5: ;
        default: ms = 0;
      endcase
    end
  end

  always @(negedge Clk) begin
    if (mvalid) begin
      logic pcw, irw, mr, mw, rw, rd, m2r, hal;
      logic [1:0] pcs, sb, ac;
      int c;
      pcw = 0; irw = 0; mr = 0; mw = 0; rw = 0; rd = 0; m2r = 0; hal = 0;
      pcs = 0; sb = 0; ac = 0;
      c = cls(Opcode);
      case (ms)
        0: begin mr = 1; if (MemReady) begin irw = 1; pcw = 1; end end
        1: if (c == C_J) begin pcw = 1; pcs = 2; end
        2: begin
          if (c == C_LW || c == C_SW) sb = 1;
          else if (c == C_BEQ) begin ac = 1; pcs = 1; pcw = Zero; end
          else begin ac = alu_of(Opcode); sb = srcb_of(Opcode); end
        end
        3: begin sb = 1; mr = (c == C_LW); mw = (c == C_SW); end
        4: begin rw = 1; rd = (c == C_R); m2r = (c == C_LW); end
        5: hal = 1;
        default: ;
      endcase
      if (Reset)
        chk("cycle_reset", {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, State, InstrCount},
            {5'b0, ms[2:0], mcnt});
      else
        chk("cycle_outputs",
            {PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, RegDst, MemToReg,
             AluSrcB, AluCtrl, Halted, State, InstrCount},
            {pcw, pcs, irw, mr, mw, rw, rd, m2r, sb, ac, hal, ms[2:0], mcnt});
    end
  end

  // Observations collected while an instruction runs
  logic       id_pcw, exe_pcw, wb_rw, wb_rd, wb_m2r;
  logic [1:0] id_pcs, exe_pcs, exe_ac, exe_sb;
  int         mem_rd, mem_wr;
  logic [11:0] seq;

  task automatic run_instr(input logic [5:0] op, input int if_wait, input int mem_wait,
                           input logic z, output int cycles);
    int  ifc, memc;
    bit  left_if;
    ifc = 0; memc = 0; left_if = 0; cycles = 0;
    id_pcw = 0; id_pcs = 0; exe_pcw = 0; exe_pcs = 0; exe_ac = 0; exe_sb = 0;
    wb_rw = 0; wb_rd = 0; wb_m2r = 0; mem_rd = 0; mem_wr = 0; seq = '0;
    Opcode = op;
    Zero   = z;
    while (cycles < 60 && !(left_if && (State == 3'd0 || State == 3'd5))) begin
      if (State == 3'd0) begin MemReady = (ifc >= if_wait); ifc++; end
      else if (State == 3'd3) begin MemReady = (memc >= mem_wait); memc++; end
      else MemReady = 1'b0;
      #1;
      if (cycles < 4) seq = {seq[8:0], State};
      case (State)
        3'd1: begin id_pcw = PCWrite; id_pcs = PCSrc; end
        3'd2: begin exe_pcw = PCWrite; exe_pcs = PCSrc; exe_ac = AluCtrl; exe_sb = AluSrcB; end
        3'd3: begin mem_rd += int'(MemRead); mem_wr += int'(MemWrite); end
        3'd4: begin wb_rw = RegWrite; wb_rd = RegDst; wb_m2r = MemToReg; end
        default: ;
      endcase
      @(posedge Clk); #1;
      cycles++;
      if (State != 3'd0) left_if = 1;
    end
    if (cycles >= 60) chk("instr_timeout", 64'(cycles), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit halt_ok;
    Reset = 1'b1; Opcode = 6'b0; Zero = 1'b0; MemReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_state", State, 3'd0);
    chk("reset_count", InstrCount, 8'd0);
    chk("reset_memread_forced", MemRead, 1'b0);
    Reset = 1'b0;

    run_instr(6'b000000, 0, 0, 0, cyc);
    chk("add_cycles", cyc, 4);
    chk("add_state_seq", seq, 12'h054);
    chk("add_wb_regwrite_rd", {wb_rw, wb_rd, wb_m2r}, 3'b110);
    chk("add_exe_aluctrl", exe_ac, 2'd0);
    chk("add_count", InstrCount, 8'd1);

    run_instr(6'b100111, 0, 2, 0, cyc);
    chk("lw_cycles", cyc, 7);
    chk("lw_memread_cycles", mem_rd, 3);
    chk("lw_wb", {wb_rw, wb_rd, wb_m2r}, 3'b101);

    run_instr(6'b110000, 0, 0, 1, cyc);
    chk("beq_taken_cycles", cyc, 3);
    chk("beq_taken_exe", {exe_pcw, exe_pcs, exe_ac}, 5'b1_01_01);
    run_instr(6'b110000, 0, 0, 0, cyc);
    chk("beq_nottaken_cycles", cyc, 3);
    chk("beq_nottaken_exe", {exe_pcw, exe_ac}, 3'b0_01);

    run_instr(6'b000101, 0, 0, 0, cyc);
    chk("ori_cycles", cyc, 4);
    chk("ori_exe", {exe_sb, exe_ac}, 4'b10_10);
    chk("ori_regdst", {wb_rw, wb_rd}, 2'b10);
    run_instr(6'b111000, 0, 0, 0, cyc);
    chk("j_cycles", cyc, 2);
    chk("j_id_pc", {id_pcw, id_pcs}, 3'b1_10);

    run_instr(6'b000001, 1, 0, 0, cyc);
    chk("sub_ifwait_cycles", cyc, 5);
    chk("sub_exe_aluctrl", exe_ac, 2'd1);
    run_instr(6'b000100, 0, 0, 0, cyc);
    chk("addi_exe", {exe_sb, exe_ac}, 4'b01_00);
    run_instr(6'b100110, 0, 0, 0, cyc);
    chk("sw_cycles", cyc, 4);
    chk("sw_memwrite_cycles", mem_wr, 1);
    run_instr(6'b001111, 0, 0, 0, cyc);
    chk("illegal_cycles", cyc, 2);
    chk("count_before_halt", InstrCount, 8'd10);

    run_instr(6'b111111, 0, 0, 0, cyc);
    chk("halt_cycles", cyc, 2);
    halt_ok = 1'b1;
    MemReady = 1'b1;
    repeat (10) begin
      @(posedge Clk); #1;
      if (!(Halted && State == 3'd5 && !PCWrite && !IRWrite && !MemRead && !MemWrite && !RegWrite))
        halt_ok = 1'b0;
    end
    chk("halt_held_10", halt_ok, 1'b1);
    chk("halt_count", InstrCount, 8'd11);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("halt_reset_state", State, 3'd0);
    chk("halt_reset_count", InstrCount, 8'd0);

    Opcode = 6'b100110; MemReady = 1'b1;
    repeat (3) begin @(posedge Clk); #1; end
    MemReady = 1'b0;
    #1;
    chk("sw_mem_state", State, 3'd3);
    chk("sw_memwrite_on", MemWrite, 1'b1);
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    chk("sw_reset_memwrite_drop", MemWrite, 1'b0);
    @(posedge Clk); #1;
    chk("sw_reset_state", State, 3'd0);
    Reset = 1'b0;

    for (int i = 0; i < 255; i++) run_instr(6'b010101, 0, 0, 0, cyc);
    chk("count_all_ones", InstrCount, 8'hFF);
    run_instr(6'b010101, 0, 0, 0, cyc);
    chk("count_wrap", InstrCount, 8'h00);

    repeat (2) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle control sequencer for the CPU datapath. It is the producer side of the ALU control interface. It steps each instruction through fetch, decode, execute, memory and write-back states. In each state it drives the 2-bit AluCtrl code the ALU consumes, plus all datapath write and read strobes. It uses the ALU's Zero flag for branch resolution and waits on memory through a ready handshake.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- Clk  input  1  system clock; all state changes on the rising edge
- Reset  input  1  synchronous, active-high reset
- Opcode  input  6  IR[31:26]; must be stable from ID until the next IF
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes the current access this cycle
- PCWrite  output  1  PC register load enable
- PCSrc  output  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target
- IRWrite  output  1  instruction register load enable
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- RegWrite  output  1  register file write enable
- RegDst  output  1  destination register: 1 = rd, 0 = rt
- MemToReg  output  1  write-back source: 1 = memory, 0 = AluResult
- AluSrcB  output  2  ALU operand B: 0 = rt, 1 = sign-extended imm16, 2 = zero-extended imm16
- AluCtrl  output  2  ALU operation: 0 = add, 1 = sub, 2 = or
- Halted  output  1  core is in HALT
- State  output  3  current state code, for debug
- InstrCount  output  CNT_W  number of retired instructions

## Operation
- Opcodes:
  - add 000000 (R-type, AluCtrl 0)
  - sub 000001 (R-type, AluCtrl 1)
  - or 000010 (R-type, AluCtrl 2)
  - addi 000100 (I-type, AluCtrl 0, AluSrcB 1)
  - ori 000101 (I-type, AluCtrl 2, AluSrcB 2)
  - lw 100111, sw 100110
  - beq 110000
  - j 111000
  - halt 111111
  - All other opcodes are illegal and execute as NOP.
- State codes: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are unreachable; if entered, the FSM goes to IF on the next edge.
- Outputs decode combinationally from the registered state and Opcode. Every strobe not listed for a state is 0, and PCSrc, AluSrcB and AluCtrl default to 0.
- IF:
  - MemRead=1.
  - When MemReady=1: IRWrite=1, PCWrite=1, PCSrc=0, go to ID.
  - Otherwise hold in IF.
- ID:
  - halt: go to HALT.
  - j: PCWrite=1, PCSrc=2, go to IF.
  - Illegal opcode: go to IF.
  - All others: go to EXE.
- EXE:
  - R-type and I-type: drive AluCtrl/AluSrcB per opcode, go to WB.
  - lw/sw: AluCtrl=0, AluSrcB=1, go to MEM.
  - beq: AluCtrl=1, AluSrcB=0, PCSrc=1, PCWrite=Zero, go to IF.
- MEM:
  - AluCtrl=0 and AluSrcB=1 are held so the address stays stable.
  - lw: MemRead=1. sw: MemWrite=1.
  - The strobe stays asserted until MemReady=1. Then lw goes to WB and sw goes to IF.
- WB:
  - RegWrite=1; go to IF.
  - R-type: RegDst=1. I-type and lw: RegDst=0.
  - lw: MemToReg=1.
- HALT: all strobes 0, Halted=1. Leaves only on Reset.
- InstrCount:
  - Increments by 1 on every edge that leaves ID, EXE, MEM or WB for IF or HALT.
  - Illegal-opcode NOPs are counted.
  - Wraps from all-ones to 0.

## Timing
- Reset:
  - On an edge with Reset=1: State=IF and InstrCount=0.
  - During any cycle with Reset=1, all strobes are forced 0: PCWrite, IRWrite, MemRead, MemWrite, RegWrite.
  - Reset overrides every state, including mid-MEM and HALT. An access in flight is abandoned and MemWrite drops in the same cycle Reset is seen.
- Cycle counts with MemReady tied high:
  - add/sub/or/addi/ori: 4 (IF, ID, EXE, WB)
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 2
  - halt: 2 to reach HALT
- Each cycle MemReady stays low in IF or MEM adds exactly one cycle. Strobes hold their values throughout the wait.
- MemReady is sampled only in IF and MEM and ignored in all other states.
- Zero is sampled only in EXE for beq. beq taken and not taken take the same number of cycles.

## Test plan
- Reset then add, MemReady=1: states 0,1,2,4,0. RegWrite=1 with RegDst=1 only in WB. AluCtrl=0 in EXE. InstrCount=1.
- lw with MemReady low for 2 cycles in MEM: MEM lasts 3 cycles with MemRead held at 1, then WB with MemToReg=1. Total 7 cycles.
- beq with Zero=1, then Zero=0: PCWrite=1 with PCSrc=1 in EXE only when Zero=1. AluCtrl=1. Both take 3 cycles.
- ori then j: ori has AluSrcB=2 and AluCtrl=2. j has PCWrite=1 with PCSrc=2 in ID and returns to IF after 2 cycles.
- halt then Reset: Halted=1 and stays high for 10 cycles with no strobes. Reset for one cycle gives State=0, InstrCount=0.
- sw with Reset asserted mid-MEM: MemWrite drops the same cycle, then State=0. Separately, preload InstrCount to all-ones via 2^CNT_W−1 NOPs, run one more and check it wraps to 0.
